// File: rtl/fs_accel_pool_ctrl.sv
// fs_accel_pool_ctrl: control sequencer for a 2x2, stride-2 max-pool datapath.
// Pixels stream in row-major order. Each row pair is compared into
// cfg_cols/2 slots, then the slots are drained one per handshake. Accepting
// pixels and draining results never overlap.
module fs_accel_pool_ctrl #(
  parameter int MAX_COLS = 26
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [4:0] cfg_cols,
  input  logic [4:0] cfg_rows,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ctl_buf_enb,
  output logic       ctl_ld_wrn,
  output logic [3:0] ctl_sel_demux,
  output logic       ctl_cp_enb,
  output logic [3:0] ctl_sel_mux,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [4:0] cols;
    logic [4:0] rows;
  } cfg_t;

  state_t     state;
  cfg_t       cfg_q;
  logic [4:0] col;
  logic [4:0] row;
  logic [3:0] k;

  logic       cfg_ok;
  logic       accept;
  logic       last_col;
  logic       last_k;

  // Both dimensions must be even and non-zero; width is bounded by the slot count.
  assign cfg_ok = !cfg_cols[0] && (cfg_cols >= 5'd2) && (int'(cfg_cols) <= MAX_COLS) &&
                  !cfg_rows[0] && (cfg_rows >= 5'd2) && (cfg_rows <= 5'd26);

  assign accept   = in_valid && in_ready;
  assign last_col = (col == 5'(cfg_q.cols - 5'd1));
  assign last_k   = (k == 4'(cfg_q.cols[4:1] - 4'd1));

  // Handshake and status decode straight off the state register.
  assign in_ready    = (state == RUN);
  assign out_valid   = (state == DRAIN);
  assign ctl_sel_mux = (state == DRAIN) ? k : 4'd0;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // Buffer control rides on the accept itself so the datapath captures this pixel.
  assign ctl_buf_enb = accept;
  assign ctl_ld_wrn  = accept && !row[0] && !col[0];

  // Sequencer: state, counters, config latch and registered control strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cfg_q         <= '0;
      col           <= '0;
      row           <= '0;
      k             <= '0;
      ctl_cp_enb    <= 1'b0;
      ctl_sel_demux <= '0;
      cfg_err       <= 1'b0;
    end else begin
      // Compare stage lags the buffer stage by one cycle; slot select holds otherwise.
      ctl_cp_enb <= accept;
      if (accept) ctl_sel_demux <= col[4:1];
      cfg_err <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              cfg_q <= '{cols: cfg_cols, rows: cfg_rows};
              col   <= '0;
              row   <= '0;
              k     <= '0;
              state <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              row <= 5'(row + 5'd1);
              // Finishing an odd row completes a row pair.
              if (row[0]) state <= FLUSH;
            end else begin
              col <= 5'(col + 5'd1);
            end
          end
        end
        FLUSH: begin
          // One cycle for the final compare strobe to land before reading slots.
          k     <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_k) begin
              k     <= '0;
              // row has already advanced past the pair just drained.
              state <= (row == cfg_q.rows) ? DONE : RUN;
            end else begin
              k <= 4'(k + 4'd1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fs_accel_pool_ctrl.sv
// Bench for fs_accel_pool_ctrl: directed configs plus random maps, checked
// against a pixel/result counting model of the pooling sequence.
module tb_fs_accel_pool_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [4:0] cfg_cols = '0;
  logic [4:0] cfg_rows = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, ctl_buf_enb, ctl_ld_wrn, ctl_cp_enb;
  logic       busy, done, cfg_err;
  logic [3:0] ctl_sel_demux, ctl_sel_mux;

  int n_chk = 0;
  int n_err = 0;
  int m_dmx = 0;  // model of the held compare-slot select

  fs_accel_pool_ctrl #(.MAX_COLS(26)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctl_buf_enb(ctl_buf_enb), .ctl_ld_wrn(ctl_ld_wrn),
    .ctl_sel_demux(ctl_sel_demux), .ctl_cp_enb(ctl_cp_enb),
    .ctl_sel_mux(ctl_sel_mux), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_buf_enb"}, ctl_buf_enb, 0);
    chk({tag, "_ld_wrn"}, ctl_ld_wrn, 0);
    chk({tag, "_cp_enb"}, ctl_cp_enb, 0);
    chk({tag, "_sel_demux"}, ctl_sel_demux, 0);
    chk({tag, "_sel_mux"}, ctl_sel_mux, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // One full map. vmode: 0 always valid, 1 every other cycle, 2 random.
  // rmode: 0 always ready, 1 random, 2 hold ready low 3 cycles at k=1.
  // A stray start with a different config is issued mid-map and must be ignored.
  task automatic run_map(input int cols, input int rows, input int vmode, input int rmode);
    int  npix, hc, nres, acc, res, stall, r, c;
    bit  ir_e, ov_e, acc_e, flush, cp_pend, done_e, fin;
    npix = cols * rows; hc = cols / 2; nres = hc * (rows / 2);
    acc = 0; res = 0; stall = 0;
    flush = 0; cp_pend = 0; done_e = 0; fin = 0;
    @(negedge clk);
    cfg_cols = 5'(cols); cfg_rows = 5'(rows); start = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("start_busy", busy, 0);
    chk("start_in_ready", in_ready, 0);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      // Pixels of a pair are accepted only once every earlier pair is drained.
      ir_e = !done_e && !flush && (acc / (2 * cols) == res / hc) && (acc < npix);
      ov_e = !done_e && !flush && (acc / (2 * cols) > res / hc);
      start = (cyc == 3);
      if (cyc == 3) begin cfg_cols = 5'd2; cfg_rows = 5'd2; end
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = !(ov_e && (res % hc == 1) && stall < 3);
          if (!out_ready) stall++;
        end
      endcase
      #1;
      acc_e = ir_e && in_valid;
      r = acc / cols; c = acc % cols;
      chk("in_ready", in_ready, ir_e);
      chk("buf_enb", ctl_buf_enb, acc_e);
      chk("ld_wrn", ctl_ld_wrn, acc_e && (r % 2 == 0) && (c % 2 == 0));
      chk("cp_enb", ctl_cp_enb, cp_pend);
      chk("sel_demux", ctl_sel_demux, m_dmx);
      chk("out_valid", out_valid, ov_e);
      chk("sel_mux", ctl_sel_mux, ov_e ? res % hc : 0);
      chk("busy", busy, 1);
      chk("done", done, done_e);
      chk("cfg_err_run", cfg_err, 0);
      if (done_e) fin = 1;
      cp_pend = acc_e;
      flush = 0;
      if (acc_e) begin
        m_dmx = c / 2;
        acc++;
        flush = (acc % (2 * cols) == 0);
      end
      if (ov_e && out_ready) begin
        res++;
        done_e = (res == nres);
      end
    end
    if (!fin) chk("map_timeout", 0, 1);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    chk("end_out_valid", out_valid, 0);
  endtask

  task automatic try_bad(input int cols, input int rows);
    @(negedge clk);
    cfg_cols = 5'(cols); cfg_rows = 5'(rows); start = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("bad_cfg_err", cfg_err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_in_ready", in_ready, 0);
    @(negedge clk);
    #1;
    chk("bad_cfg_err_clr", cfg_err, 0);
    chk("bad_busy2", busy, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    resetn = 1'b1;
    in_valid = 1'b0;

    run_map(4, 2, 0, 0);
    run_map(26, 4, 0, 0);
    run_map(6, 4, 0, 2);
    try_bad(3, 4);
    try_bad(4, 0);
    try_bad(28, 4);
    run_map(8, 4, 1, 0);

    // Reset in the middle of a map, at row 1 col 2 of a 4x4 frame.
    @(negedge clk);
    cfg_cols = 5'd4; cfg_rows = 5'd4; start = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("pre_rst_in_ready", in_ready, 1);
    resetn = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    m_dmx = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_buf_enb", ctl_buf_enb, 0);
    end
    in_valid = 1'b0;
    run_map(4, 4, 0, 0);

    for (int i = 0; i < 12; i++)
      run_map(2 * int'($urandom_range(1, 13)), 2 * int'($urandom_range(1, 13)), 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fs_accel_pool_ctrl.md
FS_ACCEL_POOL_CTRL -- requirements
Module: fs_accel_pool_ctrl

Interface
REQ-001 SHALL have parameter MAX_COLS, default 26: maximum input row width; gives 13 compare slots.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to begin one feature map.
REQ-005 SHALL have port cfg_cols, input, 5 bits: input width; legal values are even, 2..MAX_COLS.
REQ-006 SHALL have port cfg_rows, input, 5 bits: input height; legal values are even, 2..26.
REQ-007 SHALL have port in_valid, input, 1 bit: producer pixel valid; pixel data bypasses this block to the pool datapath.
REQ-008 SHALL have port in_ready, output, 1 bit: pixel accepted when in_valid & in_ready.
REQ-009 SHALL have port out_valid, output, 1 bit: pooled result is presented on the datapath output.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the pooled result.
REQ-011 SHALL have port ctl_buf_enb, output, 1 bit: datapath buffer enable.
REQ-012 SHALL have port ctl_ld_wrn, output, 1 bit: datapath buffer load/compare select; 1 = first pixel of its window.
REQ-013 SHALL have port ctl_sel_demux, output, 4 bits: compare-slot select.
REQ-014 SHALL have port ctl_cp_enb, output, 1 bit: compare-register enable.
REQ-015 SHALL have port ctl_sel_mux, output, 4 bits: output slot select.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at end of map.
REQ-018 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when start carries an illegal configuration.

Function
REQ-019 SHALL implement a 2x2, stride-2 max-pool sequencer with FSM states IDLE, RUN, FLUSH, DRAIN, DONE.
REQ-020 IDLE: start with legal cfg SHALL latch cfg_cols/cfg_rows, clear the col/row/drain counters, and go to RUN; start with illegal cfg SHALL pulse cfg_err and stay in IDLE.
REQ-021 SHALL ignore start in every state except IDLE; cfg_* changes after the latch SHALL have no effect.
REQ-022 RUN: in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-023 In a pixel-accept cycle (row r, col c), ctl_buf_enb SHALL be 1 combinationally and ctl_ld_wrn SHALL be 1 iff r and c are both even; otherwise both SHALL be 0.
REQ-024 Registered, one cycle after each accept: ctl_cp_enb SHALL be 1 and ctl_sel_demux SHALL be c>>1 (0..12).
REQ-025 ctl_sel_demux SHALL hold its last value when ctl_cp_enb = 0.
REQ-026 Counters: col SHALL increment per accepted pixel and wrap to 0 at cfg_cols-1, at which point row SHALL increment.
REQ-027 An accept at col = cfg_cols-1 on an odd row SHALL move RUN to FLUSH.
REQ-028 FLUSH SHALL last exactly 1 cycle (the last ctl_cp_enb pulse) and then go to DRAIN.
REQ-029 DRAIN: out_valid SHALL be 1 and ctl_sel_mux SHALL equal drain index k, starting at 0.
REQ-030 DRAIN: on out_valid & out_ready, k SHALL increment; out_valid SHALL stay high with ctl_sel_mux stable while out_ready = 0.
REQ-031 DRAIN exit: the handshake at k = cfg_cols/2-1 SHALL go to DONE if the last row pair was drained, otherwise to RUN with k cleared.
REQ-032 Outside DRAIN, out_valid SHALL be 0 and ctl_sel_mux SHALL be 0.
REQ-033 DONE SHALL assert done for 1 cycle and return to IDLE.
REQ-034 Total result count per map SHALL be (cfg_cols/2)*(cfg_rows/2); there SHALL be no overlap between accepting pixels and draining.

Reset
REQ-035 While resetn = 0, regardless of clock, the state SHALL be IDLE, all counters 0, and every output 0, including in_ready, ctl_sel_demux and ctl_sel_mux.
REQ-036 Reset asserted mid-RUN or mid-DRAIN SHALL abandon the map; after release, the block SHALL require a new start.

Verification
REQ-037 cols=4, rows=2, in_valid held 1 -> ld_wrn pattern 1,0,1,0,0,0,0,0; sel_demux 0,0,1,1,0,0,1,1; FLUSH; 2 outputs with sel_mux 0,1; done pulse.
REQ-038 cols=26, rows=4 -> 13 outputs per row pair (sel_mux 0..12), 26 total; busy high from the cycle after start until done.
REQ-039 DRAIN with out_ready low for 3 cycles at k=1 -> sel_mux holds 1 and out_valid stays 1; in_ready stays 0.
REQ-040 start with cols=3, with rows=0, or with cols=28 -> cfg_err pulse, busy stays 0; a second start while busy -> ignored.
REQ-041 in_valid gaps (every other cycle) -> ctl_cp_enb pulses exactly one cycle after each accept; counts are unchanged.
REQ-042 resetn dropped mid-RUN at row 1, col 2 -> all outputs 0 immediately; next legal start restarts at row 0, col 0.
